// File: rtl/split_check_sequencer.sv
// split_check_sequencer
//
// Purpose: sequences the constraint-split checkers of the candidate-validation
// stage. For each solve it requests a candidate from the generator and walks
// split checkers 0..NUM_SPLITS-1 in order through an external select mux. The
// first failing split rejects the candidate, and a fresh one is requested.
// This repeats until every split passes, the attempt budget runs out, or the
// solve is aborted.
//
// Ports:
//   clk, rst       rising-edge clock; asynchronous active-high reset
//   start          single-cycle solve request, accepted only in IDLE
//   max_tries      attempt budget sampled on accepted start (0 = unlimited)
//   abort          ends the current solve with a fail result
//   busy           high from the cycle after start through the done cycle
//   cand_req       candidate request, held until cand_vld
//   cand_vld       generator acknowledge
//   split_sel      index of the split checker being evaluated
//   split_vld      one-cycle evaluate strobe for split_sel
//   split_res_vld  checker result strobe
//   split_res      1 = split satisfied
//   done           one-cycle completion pulse
//   pass           result of the last solve
//   fail_idx       index of the most recent failing split
//   tries          candidates consumed, saturating at all-ones
module split_check_sequencer #(
  parameter int NUM_SPLITS = 64,
  parameter int IDX_W      = 6,
  parameter int TRY_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [TRY_W-1:0] max_tries,
  input  logic             abort,
  output logic             busy,
  output logic             cand_req,
  input  logic             cand_vld,
  output logic [IDX_W-1:0] split_sel,
  output logic             split_vld,
  input  logic             split_res_vld,
  input  logic             split_res,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] fail_idx,
  output logic [TRY_W-1:0] tries
);

  typedef enum logic [2:0] {IDLE, REQ, ISSUE, WAIT, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPLITS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [TRY_W-1:0] budget;
  logic [TRY_W-1:0] tries_inc;
  logic             budget_spent;

  // The attempt counter sticks at all-ones so an unlimited solve never wraps.
  assign tries_inc    = (tries == '1) ? tries : tries + TRY_W'(1);
  // A zero budget means unlimited retries.
  assign budget_spent = (budget != '0) && (tries >= budget);

  // Decoded straight from the state register so neither strobe has a
  // combinational path from any input.
  assign cand_req  = (state == REQ);
  assign split_vld = (state == ISSUE);
  assign split_sel = idx;

  // Main controller. Abort is checked before any handshake in the active
  // states so that a coincident cand_vld or split_res_vld is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      budget   <= '0;
      tries    <= '0;
      pass     <= 1'b0;
      fail_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= REQ;
            busy     <= 1'b1;
            tries    <= '0;
            pass     <= 1'b0;
            fail_idx <= '0;
            budget   <= max_tries;
          end
        end
        REQ: begin
          if (abort) begin
            pass  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (cand_vld) begin
            tries <= tries_inc;
            idx   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort) begin
            pass  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            pass  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (split_res_vld) begin
            if (split_res) begin
              if (idx == LAST_IDX) begin
                pass  <= 1'b1;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= ISSUE;
              end
            end else begin
              fail_idx <= idx;
              if (budget_spent) begin
                pass  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= REQ;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_split_check_sequencer.sv
// tb_split_check_sequencer
//
// Directed bench for split_check_sequencer with NUM_SPLITS=4, IDX_W=2 and
// TRY_W=4 (small enough to reach tries saturation quickly). Inputs are driven
// and outputs sampled 1 ns after each rising edge.
module tb_split_check_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] max_tries = '0;
  logic       abort = 1'b0;
  logic       busy;
  logic       cand_req;
  logic       cand_vld = 1'b0;
  logic [1:0] split_sel;
  logic       split_vld;
  logic       split_res_vld = 1'b0;
  logic       split_res = 1'b0;
  logic       done;
  logic       pass;
  logic [1:0] fail_idx;
  logic [3:0] tries;

  int tests_run = 0;
  int tests_failed = 0;

  // Results gathered by drive_solve.
  bit d_done_seen, d_req_drop, d_busy_gap, d_busy_c1, d_req_c1;
  int d_done_cyc, d_pulses, d_xfers, d_results;
  int d_seq [0:31];

  split_check_sequencer #(.NUM_SPLITS(4), .IDX_W(2), .TRY_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .max_tries(max_tries), .abort(abort),
    .busy(busy), .cand_req(cand_req), .cand_vld(cand_vld), .split_sel(split_sel),
    .split_vld(split_vld), .split_res_vld(split_res_vld), .split_res(split_res),
    .done(done), .pass(pass), .fail_idx(fail_idx), .tries(tries)
  );

  always #5 clk = ~clk;

  // Behavioural generator and checker. The generator answers cand_req after
  // gen_wait stall cycles; the checker answers chk_wait+1 cycles after each
  // split_vld. Split fail_split fails on candidates 1..fail_upto.
  task automatic drive_solve(input logic [3:0] budget, input int gen_wait,
                             input int chk_wait, input int fail_split,
                             input int fail_upto, input int limit);
    int gen_cnt, wait_cnt, cand_num, pend_idx;
    bit pending, req_pending;
    gen_cnt = 0; wait_cnt = 0; cand_num = 0; pend_idx = 0;
    pending = 0; req_pending = 0;
    d_done_seen = 0; d_req_drop = 0; d_busy_gap = 0; d_busy_c1 = 0; d_req_c1 = 0;
    d_done_cyc = 0; d_pulses = 0; d_xfers = 0; d_results = 0;
    @(posedge clk); #1;
    start = 1'b1; max_tries = budget;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == 1) begin d_busy_c1 = busy; d_req_c1 = cand_req; end
      if (!busy) d_busy_gap = 1;
      if (done) begin
        d_done_seen = 1; d_done_cyc = cyc;
        cand_vld = 1'b0; split_res_vld = 1'b0; split_res = 1'b0;
        break;
      end
      if (req_pending && !cand_req) d_req_drop = 1;
      cand_vld = 1'b0;
      if (cand_req) begin
        if (gen_cnt >= gen_wait) begin
          cand_vld = 1'b1; d_xfers++; cand_num++; gen_cnt = 0; req_pending = 0;
        end else begin
          gen_cnt++; req_pending = 1;
        end
      end
      split_res_vld = 1'b0; split_res = 1'b0;
      if (pending) begin
        if (wait_cnt >= chk_wait) begin
          split_res_vld = 1'b1;
          split_res = !(pend_idx == fail_split && cand_num <= fail_upto);
          d_results++; pending = 0;
        end else begin
          wait_cnt++;
        end
      end
      if (split_vld) begin
        if (d_pulses < 32) d_seq[d_pulses] = int'(split_sel);
        d_pulses++; pending = 1; wait_cnt = 0; pend_idx = int'(split_sel);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, cand_req, split_vld, done, pass} !== 5'b0 || split_sel !== 2'd0 ||
        fail_idx !== 2'd0 || tries !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: busy=%b req=%b vld=%b done=%b pass=%b sel=%0d fidx=%0d tries=%0d, all required 0",
               busy, cand_req, split_vld, done, pass, split_sel, fail_idx, tries);
    end
    rst = 1'b0;
  endtask

  task automatic test_all_pass();
    drive_solve(4'd3, 0, 0, 0, 0, 40);
    tests_run++;
    if (d_busy_c1 !== 1'b1 || d_req_c1 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL start_latency: busy=%b cand_req=%b in cycle 1, required 1 1", d_busy_c1, d_req_c1);
    end
    tests_run++;
    if (d_done_seen !== 1'b1 || d_done_cyc + 1 != 11) begin
      tests_failed++;
      $display("[TB] FAIL all_pass_latency: done_seen=%b span=%0d cycles, required 11", d_done_seen, d_done_cyc + 1);
    end
    tests_run++;
    if (d_pulses != 4 || d_seq[0] != 0 || d_seq[1] != 1 || d_seq[2] != 2 || d_seq[3] != 3) begin
      tests_failed++;
      $display("[TB] FAIL split_order: pulses=%0d seq=%0d %0d %0d %0d, required 4 pulses 0 1 2 3",
               d_pulses, d_seq[0], d_seq[1], d_seq[2], d_seq[3]);
    end
    tests_run++;
    if (pass !== 1'b1 || tries !== 4'd1 || busy !== 1'b1 || d_busy_gap) begin
      tests_failed++;
      $display("[TB] FAIL all_pass_result: pass=%b tries=%0d busy=%b gap=%b, required 1 1 1 0", pass, tries, busy, d_busy_gap);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL after_done: done=%b busy=%b pass=%b, required 0 0 1", done, busy, pass);
    end
  endtask

  task automatic test_retry_pass();
    drive_solve(4'd3, 0, 0, 2, 1, 60);
    tests_run++;
    if (d_done_seen !== 1'b1 || pass !== 1'b1 || fail_idx !== 2'd2 || tries !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL retry_pass: done=%b pass=%b fail_idx=%0d tries=%0d, required 1 1 2 2",
               d_done_seen, pass, fail_idx, tries);
    end
    tests_run++;
    if (d_pulses != 7 || d_xfers != 2) begin
      tests_failed++;
      $display("[TB] FAIL retry_pulses: split_vld=%0d xfers=%0d, required 7 2", d_pulses, d_xfers);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_budget_exhausted();
    drive_solve(4'd3, 0, 0, 1, 99, 80);
    tests_run++;
    if (d_done_seen !== 1'b1 || pass !== 1'b0 || fail_idx !== 2'd1 || tries !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL budget_result: done=%b pass=%b fail_idx=%0d tries=%0d, required 1 0 1 3",
               d_done_seen, pass, fail_idx, tries);
    end
    tests_run++;
    if (d_xfers != 3) begin
      tests_failed++;
      $display("[TB] FAIL budget_xfers: got %0d transfers, required 3", d_xfers);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (cand_req !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL no_fourth_req: cand_req=%b %0d cycles after done, required 0", cand_req, i + 1);
      end
    end
  endtask

  task automatic test_abort();
    @(posedge clk); #1; start = 1'b1; max_tries = 4'd3;
    @(posedge clk); #1; start = 1'b0; cand_vld = 1'b1;
    @(posedge clk); #1; cand_vld = 1'b0;
    tests_run++;
    if (split_vld !== 1'b1 || split_sel !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_issue: split_vld=%b sel=%0d, required 1 0", split_vld, split_sel);
    end
    start = 1'b1; max_tries = 4'd1;
    @(posedge clk); #1; start = 1'b0;
    tests_run++;
    if (split_vld !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL busy_start_ignored: split_vld=%b busy=%b, required 0 1", split_vld, busy);
    end
    abort = 1'b1; split_res_vld = 1'b1; split_res = 1'b1;
    @(posedge clk); #1; abort = 1'b0; split_res_vld = 1'b0; split_res = 1'b0;
    tests_run++;
    if (done !== 1'b1 || pass !== 1'b0 || split_sel !== 2'd0 || tries !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL abort_done: done=%b pass=%b sel=%0d tries=%0d, required 1 0 0 1", done, pass, split_sel, tries);
    end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || cand_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL done_start_ignored: done=%b busy=%b cand_req=%b, required 0 0 0", done, busy, cand_req);
    end
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (split_vld !== 1'b0 || cand_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_abort_ignored: vld=%b req=%b busy=%b done=%b, required 0 0 0 0", split_vld, cand_req, busy, done);
    end
  endtask

  task automatic test_slow_handshake();
    drive_solve(4'd3, 5, 3, 0, 0, 120);
    tests_run++;
    if (d_done_seen !== 1'b1 || d_req_drop || pass !== 1'b1 || tries !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL slow_result: done=%b req_drop=%b pass=%b tries=%0d, required 1 0 1 1",
               d_done_seen, d_req_drop, pass, tries);
    end
    tests_run++;
    if (d_pulses != 4 || d_results != 4) begin
      tests_failed++;
      $display("[TB] FAIL slow_pulses: split_vld=%0d results=%0d, required 4 4", d_pulses, d_results);
    end
    @(posedge clk); #1;
    split_res_vld = 1'b1; split_res = 1'b0;
    @(posedge clk); #1; split_res_vld = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || split_vld !== 1'b0 || cand_req !== 1'b0 || fail_idx !== 2'd0 || pass !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL idle_res_ignored: busy=%b vld=%b req=%b fidx=%0d pass=%b, required 0 0 0 0 1",
               busy, split_vld, cand_req, fail_idx, pass);
    end
  endtask

  task automatic test_saturation();
    drive_solve(4'd0, 0, 0, 0, 1000, 60);
    tests_run++;
    if (d_done_seen !== 1'b0 || tries !== 4'd15 || d_xfers <= 15 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL tries_saturate: done=%b tries=%0d xfers=%0d busy=%b, required 0 15 >15 1",
               d_done_seen, tries, d_xfers, busy);
    end
    @(posedge clk); #1;
    abort = 1'b1; cand_vld = 1'b0; split_res_vld = 1'b0; split_res = 1'b0;
    @(posedge clk); #1; abort = 1'b0;
    tests_run++;
    if (done !== 1'b1 || pass !== 1'b0 || fail_idx !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL saturate_abort: done=%b pass=%b fidx=%0d, required 1 0 0", done, pass, fail_idx);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1; start = 1'b1; max_tries = 4'd3;
    @(posedge clk); #1; start = 1'b0; cand_vld = 1'b1;
    @(posedge clk); #1; cand_vld = 1'b0;
    @(posedge clk); #1; split_res_vld = 1'b1; split_res = 1'b0;
    @(posedge clk); #1; split_res_vld = 1'b0; cand_vld = 1'b1;
    @(posedge clk); #1; cand_vld = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (tries !== 4'd2 || busy !== 1'b1 || split_vld !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset: tries=%0d busy=%b vld=%b, required 2 1 0", tries, busy, split_vld);
    end
    rst = 1'b1;
    #2;
    tests_run++;
    if ({busy, cand_req, split_vld, done, pass} !== 5'b0 || split_sel !== 2'd0 ||
        fail_idx !== 2'd0 || tries !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: busy=%b req=%b vld=%b done=%b pass=%b sel=%0d fidx=%0d tries=%0d, all required 0",
               busy, cand_req, split_vld, done, pass, split_sel, fail_idx, tries);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_solve(4'd3, 0, 0, 0, 0, 40);
    tests_run++;
    if (d_done_seen !== 1'b1 || pass !== 1'b1 || tries !== 4'd1 || d_pulses != 4) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_solve: done=%b pass=%b tries=%0d pulses=%0d, required 1 1 1 4",
               d_done_seen, pass, tries, d_pulses);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_retry_pass();
    test_budget_exhausted();
    test_abort();
    test_slow_handshake();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/split_check_sequencer.md
# split_check_sequencer

Sequences evaluation of the constraint-split checkers of the BDD solver's candidate-validation stage. It requests a candidate assignment from the stimulus generator, then walks split checkers 0..NUM_SPLITS-1 one at a time through an external select mux. It aborts a candidate on the first failing split and retries with a fresh candidate until every split passes or the attempt budget is exhausted. It sits between the candidate generator and the bank of split checker modules.

## Interface
- NUM_SPLITS, default 64: number of split checkers; must be ≥ 2.
- IDX_W, default 6: width of split index; must satisfy 2^IDX_W ≥ NUM_SPLITS.
- TRY_W, default 16: width of attempt counter and budget.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a solve; ignored while busy.
- max_tries  in  TRY_W  attempt budget, sampled on accepted start; 0 = unlimited.
- abort  in  1  terminate the current solve (fail result).
- busy  out  1  high from the cycle after accepted start until the cycle done is asserted, inclusive.
- cand_req  out  1  request for a new candidate; held until cand_vld.
- cand_vld  in  1  generator acknowledge; a transfer happens when cand_req && cand_vld.
- split_sel  out  IDX_W  index of the split checker being evaluated.
- split_vld  out  1  one-cycle pulse: evaluate split_sel against the current candidate.
- split_res_vld  in  1  checker result strobe.
- split_res  in  1  1 = split satisfied; qualified by split_res_vld.
- done  out  1  one-cycle completion pulse.
- pass  out  1  result of the last solve; held until the next accepted start.
- fail_idx  out  IDX_W  index of the most recent failing split; held.
- tries  out  TRY_W  candidates consumed in the current/last solve; saturates at all-ones.

## Operation
- States: IDLE, REQ, ISSUE, WAIT, DONE.
- IDLE: start → REQ; clear tries, pass, fail_idx; latch max_tries.
- REQ: cand_req=1. On cand_vld: tries+1 (saturating), idx←0 → ISSUE.
- ISSUE: split_vld=1, split_sel=idx → WAIT. split_sel holds idx in every state; it is 0 after reset.
- WAIT: waits indefinitely for split_res_vld.
  - res=1, idx<NUM_SPLITS-1: idx+1 → ISSUE.
  - res=1, idx=NUM_SPLITS-1: pass←1 → DONE.
  - res=0: fail_idx←idx. If max_tries≠0 and tries≥max_tries: pass←0 → DONE. Otherwise → REQ.
- DONE: done=1 for one cycle → IDLE.
- abort in REQ/ISSUE/WAIT → DONE with pass=0 next cycle. This takes priority over a same-cycle cand_vld or split_res_vld, which are then ignored. abort in IDLE/DONE is ignored.
- split_res_vld outside WAIT is ignored. cand_vld without cand_req is ignored.
- start in the DONE cycle is ignored; start is accepted only in IDLE.
- Tries saturation with max_tries=0: the counter stops at all-ones and retries continue.

## Timing
- Reset values: busy=0, cand_req=0, split_vld=0, split_sel=0, done=0, pass=0, fail_idx=0, tries=0; state IDLE.
- All outputs are registered, except cand_req and split_vld, which are decoded from the state register (glitch-free, no input-to-output combinational path).
- start at cycle 0 → busy and cand_req high in cycle 1.
- cand_vld at cycle k → split_vld at k+1.
- split_res_vld at cycle m:
  - pass, not last → next split_vld at m+1.
  - fail with retry → cand_req at m+1.
  - terminal → done at m+1.
- With zero-wait generator and checker (res one cycle after split_vld): all-pass solve start→done = 3 + 2·NUM_SPLITS cycles.
- Asynchronous rst mid-solve returns to IDLE immediately; all outputs take their reset values; no done pulse.

## Test plan
- NUM_SPLITS=4, max_tries=3, cand_vld immediate, all splits pass → split_sel 0,1,2,3, done at cycle 11, pass=1, tries=1.
- Split 2 fails on candidate 1, all pass on candidate 2 → fail_idx=2, tries=2, pass=1, exactly 7 split_vld pulses.
- Split 1 always fails, max_tries=3 → 3 cand_req transfers, done with pass=0, fail_idx=1, tries=3; no fourth cand_req.
- abort asserted in WAIT coincident with split_res_vld=1 → done next cycle, pass=0, no further split_vld; start pulsed during busy is ignored.
- Generator stalls cand_vld 5 cycles and checker takes 4 cycles per result → cand_req held continuously; exactly one split_vld per result; spurious split_res_vld in IDLE ignored.
- rst asserted in WAIT → all outputs 0 asynchronously; a subsequent start runs a full solve normally with tries restarting at 1.
